vec_ex_stage: RTL

- Vector execute pipeline stage that sits between vector decode/register-read and writeback.
- Accepts one decoded vector operation per cycle over a valid/ready handshake and latches operands into an ID/EX register.
- Resolves read-after-write hazards by forwarding results from its own two in-flight slots, drives the combinational lane-wise vector ALU (alu_vec), and registers the result into an EX/WB register with the destination tag.
- Maintains a retired-operation counter.

---
 rtl/vec_pkg.sv | 25 ++
 rtl/alu_vec.sv | 30 +++
 rtl/vec_fwd_mux.sv | 27 ++
 rtl/vec_ex_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and opcode constants for the vector execute slice.
package vec_pkg;

  localparam int VECTOR_SIZE = 256;
  localparam int ELEMENT     = 16;
  localparam int REG_W       = 4;

  typedef logic [VECTOR_SIZE-1:0] vec_t;
  typedef logic [REG_W-1:0]       reg_idx_t;
  typedef logic [2:0]             opcode_t;

  localparam opcode_t OP_ADD = 3'b000;
  localparam opcode_t OP_SUB = 3'b001;
  localparam opcode_t OP_AND = 3'b010;
  localparam opcode_t OP_OR  = 3'b011;
  localparam opcode_t OP_XOR = 3'b100;

  typedef struct packed {
    opcode_t  opcode;
    vec_t     a;
    vec_t     b;
    reg_idx_t rd;
  } ex_op_t;

endpackage

// File: rtl/alu_vec.sv
// Combinational lane-wise vector ALU; each ELEMENT-wide lane wraps independently.
module alu_vec
  import vec_pkg::*;
#(
  parameter int VECTOR_SIZE = 256,
  parameter int ELEMENT     = 16
) (
  input  logic [VECTOR_SIZE-1:0] a,
  input  logic [VECTOR_SIZE-1:0] b,
  input  logic [2:0]             opcode,
  output logic [VECTOR_SIZE-1:0] y
);

  localparam int LANES = VECTOR_SIZE / ELEMENT;

  always_comb begin
    y = '0;
    for (int i = 0; i < LANES; i++) begin
      unique case (opcode)
        OP_ADD:  y[i*ELEMENT +: ELEMENT] = a[i*ELEMENT +: ELEMENT] + b[i*ELEMENT +: ELEMENT];
        OP_SUB:  y[i*ELEMENT +: ELEMENT] = a[i*ELEMENT +: ELEMENT] - b[i*ELEMENT +: ELEMENT];
        OP_AND:  y[i*ELEMENT +: ELEMENT] = a[i*ELEMENT +: ELEMENT] & b[i*ELEMENT +: ELEMENT];
        OP_OR:   y[i*ELEMENT +: ELEMENT] = a[i*ELEMENT +: ELEMENT] | b[i*ELEMENT +: ELEMENT];
        OP_XOR:  y[i*ELEMENT +: ELEMENT] = a[i*ELEMENT +: ELEMENT] ^ b[i*ELEMENT +: ELEMENT];
        default: y[i*ELEMENT +: ELEMENT] = '0;
      endcase
    end
  end

endmodule

// File: rtl/vec_fwd_mux.sv
// Per-operand forwarding select: youngest in-flight producer (S1) wins over S2, else register file.
module vec_fwd_mux #(
  parameter int VECTOR_SIZE = 256,
  parameter int REG_W       = 4
) (
  input  logic [REG_W-1:0]       rs,
  input  logic                   rs_en,
  input  logic                   s1_valid,
  input  logic [REG_W-1:0]       s1_rd,
  input  logic [VECTOR_SIZE-1:0] s1_value,
  input  logic                   s2_valid,
  input  logic [REG_W-1:0]       s2_rd,
  input  logic [VECTOR_SIZE-1:0] s2_value,
  input  logic [VECTOR_SIZE-1:0] rf_value,
  output logic [VECTOR_SIZE-1:0] operand
);

  always_comb begin
    operand = rf_value;
    if (rs_en && s1_valid && (s1_rd == rs)) begin
      operand = s1_value;
    end else if (rs_en && s2_valid && (s2_rd == rs)) begin
      operand = s2_value;
    end
  end

endmodule

// File: rtl/vec_ex_stage.sv
// Vector execute stage: ID/EX slot feeding alu_vec, EX/WB result slot, in-stage forwarding.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds until then.
module vec_ex_stage
  import vec_pkg::*;
#(
  parameter int VECTOR_SIZE = 256,
  parameter int ELEMENT     = 16,
  parameter int REG_W       = 4,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_opcode,
  input  logic [VECTOR_SIZE-1:0] in_vec_a,
  input  logic [VECTOR_SIZE-1:0] in_vec_b,
  input  logic [REG_W-1:0]       in_rs_a,
  input  logic [REG_W-1:0]       in_rs_b,
  input  logic                   in_rs_a_en,
  input  logic                   in_rs_b_en,
  input  logic [REG_W-1:0]       in_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VECTOR_SIZE-1:0] out_result,
  output logic [REG_W-1:0]       out_rd,
  output logic [CNT_W-1:0]       ops_retired
);

  logic                   s1_valid;
  logic [2:0]             s1_opcode;
  logic [VECTOR_SIZE-1:0] s1_a;
  logic [VECTOR_SIZE-1:0] s1_b;
  logic [REG_W-1:0]       s1_rd;

  logic                   s2_valid;
  logic [VECTOR_SIZE-1:0] s2_result;
  logic [REG_W-1:0]       s2_rd;

  logic                   s2_load;
  logic                   s1_adv;
  logic                   accept;
  logic [VECTOR_SIZE-1:0] alu_y;
  logic [VECTOR_SIZE-1:0] fwd_a;
  logic [VECTOR_SIZE-1:0] fwd_b;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !flush && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

  alu_vec #(
    .VECTOR_SIZE(VECTOR_SIZE),
    .ELEMENT    (ELEMENT)
  ) u_alu (
    .a     (s1_a),
    .b     (s1_b),
    .opcode(s1_opcode),
    .y     (alu_y)
  );

  // An accept never coincides with flush (in_ready is low), so S1 is always live here.
  vec_fwd_mux #(.VECTOR_SIZE(VECTOR_SIZE), .REG_W(REG_W)) u_fwd_a (
    .rs      (in_rs_a),
    .rs_en   (in_rs_a_en),
    .s1_valid(s1_valid),
    .s1_rd   (s1_rd),
    .s1_value(alu_y),
    .s2_valid(s2_valid),
    .s2_rd   (s2_rd),
    .s2_value(s2_result),
    .rf_value(in_vec_a),
    .operand (fwd_a)
  );

  vec_fwd_mux #(.VECTOR_SIZE(VECTOR_SIZE), .REG_W(REG_W)) u_fwd_b (
    .rs      (in_rs_b),
    .rs_en   (in_rs_b_en),
    .s1_valid(s1_valid),
    .s1_rd   (s1_rd),
    .s1_value(alu_y),
    .s2_valid(s2_valid),
    .s2_rd   (s2_rd),
    .s2_value(s2_result),
    .rf_value(in_vec_b),
    .operand (fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_rd     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_opcode <= in_opcode;
      s1_a      <= fwd_a;
      s1_b      <= fwd_b;
      s1_rd     <= in_rd;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // A flushed S1 enters S2 as a bubble; S2 itself is never killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_rd     <= '0;
    end else if (s2_load) begin
      s2_valid  <= s1_valid && !flush;
      s2_result <= alu_y;
      s2_rd     <= s1_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_retired <= '0;
    end else if (s2_valid && out_ready && (ops_retired != {CNT_W{1'b1}})) begin
      ops_retired <= ops_retired + 1'b1;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_rd     = s2_rd;

endmodule
